// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a one-cycle turnaround gap and a bounded hold time.
// Drives a 3x8 decoder through gnt_bin/gnt_en and also provides a registered one-hot grant.
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] gnt_bin,
   output logic       gnt_en,
   output logic [7:0] gnt,
   output logic       timeout
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   // Last cycle a grant may stay asserted before it is forcibly revoked.
   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [2:0] gnt_bin_q, gnt_bin_d;
   logic       gnt_en_q, gnt_en_d;
   logic [7:0] gnt_q, gnt_d;
   logic       timeout_q, timeout_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] scan_idx;

   // Find the first requester at or after ptr, wrapping modulo 8.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      scan_idx  = 3'd0;
      for (int k = 0; k < 8; k++) begin
         scan_idx = ptr_q + 3'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // Next-state logic: arbitrate in IDLE/GAP, track hold time and release in GRANT.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_bin_d  = gnt_bin_q;
      gnt_en_d   = gnt_en_q;
      gnt_d      = gnt_q;
      timeout_d  = 1'b0;

      case (state_q)
         StIdle, StGap: begin
            if (win_found) begin
               state_d    = StGrant;
               gnt_bin_d  = win_idx;
               gnt_en_d   = 1'b1;
               gnt_d      = 8'b0000_0001 << win_idx;
               ptr_d      = win_idx + 3'd1;
               hold_cnt_d = 8'd0;
            end else begin
               state_d  = StIdle;
               gnt_en_d = 1'b0;
               gnt_d    = 8'h00;
            end
         end
         StGrant: begin
            // A voluntary release takes priority over the hold limit, so done on the
            // final cycle never raises timeout. gnt_bin keeps the last winner.
            if (done || !req[gnt_bin_q]) begin
               state_d  = StGap;
               gnt_en_d = 1'b0;
               gnt_d    = 8'h00;
            end else if (hold_cnt_q == HoldLast) begin
               state_d   = StGap;
               gnt_en_d  = 1'b0;
               gnt_d     = 8'h00;
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d  = StIdle;
            gnt_en_d = 1'b0;
            gnt_d    = 8'h00;
         end
      endcase
   end

   // State and output registers; outputs clear immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= 3'd0;
         hold_cnt_q <= 8'd0;
         gnt_bin_q  <= 3'd0;
         gnt_en_q   <= 1'b0;
         gnt_q      <= 8'h00;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_bin_q  <= gnt_bin_d;
         gnt_en_q   <= gnt_en_d;
         gnt_q      <= gnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt_bin = gnt_bin_q;
   assign gnt_en  = gnt_en_q;
   assign gnt     = gnt_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: a cycle model fills a scoreboard queue as stimulus is
// driven, entries are popped and compared after each edge, plus directed scenario checks.
module tb_rr_arbiter_8;

   localparam int MaxHold = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] gnt_bin;
   logic       gnt_en;
   logic [7:0] gnt;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] bin;
      logic       en;
      logic [7:0] gnt;
      logic       to;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state (0 idle, 1 grant, 2 gap).
   int         m_state;
   int         m_ptr;
   int         m_hold;
   logic [2:0] m_bin;
   logic       m_en;
   logic [7:0] m_gnt;
   logic       m_to;

   rr_arbiter_8 #(.MAX_HOLD(MaxHold)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt_bin (gnt_bin),
      .gnt_en  (gnt_en),
      .gnt     (gnt),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ptr   = 0;
      m_hold  = 0;
      m_bin   = 3'd0;
      m_en    = 1'b0;
      m_gnt   = 8'h00;
      m_to    = 1'b0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      int w;
      w = -1;
      m_to = 1'b0;
      if (m_state != 1) begin
         for (int k = 0; k < 8; k++) begin
            if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
         end
         if (w >= 0) begin
            m_state = 1;
            m_bin   = 3'(w);
            m_en    = 1'b1;
            m_gnt   = 8'h00;
            m_gnt[w] = 1'b1;
            m_ptr   = (w + 1) % 8;
            m_hold  = 0;
         end else begin
            m_state = 0;
            m_en    = 1'b0;
            m_gnt   = 8'h00;
         end
      end else begin
         if (done || !req[m_bin]) begin
            m_state = 2;
            m_en    = 1'b0;
            m_gnt   = 8'h00;
         end else if (m_hold == MaxHold - 1) begin
            m_state = 2;
            m_en    = 1'b0;
            m_gnt   = 8'h00;
            m_to    = 1'b1;
         end else begin
            m_hold++;
         end
      end
   endtask

   // One clock: predict, push, take the edge, then pop and compare away from the edge.
   task automatic step();
      exp_t e;
      model_edge();
      sb_q.push_back('{bin: m_bin, en: m_en, gnt: m_gnt, to: m_to});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_eq("sb_gnt_bin", 32'(gnt_bin), 32'(e.bin));
      check_eq("sb_gnt_en", 32'(gnt_en), 32'(e.en));
      check_eq("sb_gnt", 32'(gnt), 32'(e.gnt));
      check_eq("sb_timeout", 32'(timeout), 32'(e.to));
   endtask

   // Pulse reset between clock edges (called from posedge+1).
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_gnt", 32'(gnt), 32'h00);
      check_eq("rst_gnt_en", 32'(gnt_en), 32'h0);
      check_eq("rst_gnt_bin", 32'(gnt_bin), 32'h0);
      check_eq("rst_timeout", 32'(timeout), 32'h0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      model_reset();
      #1;
      check_eq("init_gnt", 32'(gnt), 32'h00);
      check_eq("init_gnt_en", 32'(gnt_en), 32'h0);
      @(posedge clk);
      #1;
      #4 rst_n = 1'b1;
      step();

      // Reset mid-grant on requester 5, then restart from ptr=0.
      req = 8'h20;
      step();
      check_eq("grant5_bin", 32'(gnt_bin), 32'd5);
      pulse_reset();
      req = 8'h04;
      step();
      check_eq("post_rst_gnt", 32'(gnt), 32'h04);
      check_eq("post_rst_bin", 32'(gnt_bin), 32'd2);

      // Round robin with everyone requesting; done pulsed in each grant cycle.
      @(posedge clk);
      #1;
      model_reset();
      pulse_reset();
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         done = 1'b0;
         step();
         check_eq("rr_winner", 32'(gnt_bin), 32'(i % 8));
         done = 1'b1;
         step();
         check_eq("rr_gap", 32'(gnt), 32'h00);
      end

      // Wrap priority: grant 6, release, then 8'h81 gives 7 followed by 0.
      req  = 8'h40;
      done = 1'b0;
      step();
      check_eq("wrap_grant6", 32'(gnt_bin), 32'd6);
      done = 1'b1;
      step();
      req  = 8'h81;
      done = 1'b0;
      step();
      check_eq("wrap_grant7", 32'(gnt), 32'h80);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      check_eq("wrap_grant0", 32'(gnt), 32'h01);

      // Timeout: requester 3 held for MaxHold cycles, one-cycle pulse, then regranted.
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 8'h08;
      step();
      for (int i = 1; i < MaxHold; i++) begin
         step();
         check_eq("hold_gnt", 32'(gnt), 32'h08);
      end
      step();
      check_eq("to_gnt", 32'(gnt), 32'h00);
      check_eq("to_pulse", 32'(timeout), 32'h1);
      step();
      check_eq("to_regrant", 32'(gnt), 32'h08);
      check_eq("to_cleared", 32'(timeout), 32'h0);

      // Done on the final hold cycle releases without timeout.
      for (int i = 1; i < MaxHold; i++) step();
      done = 1'b1;
      step();
      check_eq("final_done_en", 32'(gnt_en), 32'h0);
      check_eq("final_done_to", 32'(timeout), 32'h0);
      done = 1'b0;

      // Requester drop: 5 granted, req[5] falls, ptr advances to 6.
      req = 8'h20;
      step();
      check_eq("drop_grant5", 32'(gnt_bin), 32'd5);
      req = 8'h00;
      step();
      check_eq("drop_en", 32'(gnt_en), 32'h0);
      check_eq("drop_to", 32'(timeout), 32'h0);
      req = 8'h61;
      step();
      check_eq("drop_ptr6", 32'(gnt_bin), 32'd6);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         req  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         done = ($urandom_range(0, 3) == 0);
         step();
      end

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one decoded resource, such as a bus or register-file write port, among eight requesters. It produces the 3-bit select and enable pair that drives the team's 3x8 decoder, plus a registered one-hot grant vector. It enforces a one-cycle turnaround gap between owners and a bounded hold time per grant.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant stays asserted; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  level request per requester; bit i belongs to requester i.
- done  in  1  current owner releases the grant; ignored unless a grant is active.
- gnt_bin  out  3  index of the current or last winner; drives the decoder select.
- gnt_en  out  1  grant valid; drives the decoder enable.
- gnt  out  8  registered one-hot grant; equals decode(gnt_bin) when gnt_en=1, else 8'h00.
- timeout  out  1  one-cycle pulse when a grant was forcibly revoked.

## Operation
- Three states: IDLE, GRANT, GAP. Internal state: round-robin pointer ptr[2:0] and hold counter hold_cnt[7:0].
- **Arbitration** (done in IDLE and GAP):
  - Winner = first i with req[i]=1, searching ptr, ptr+1, … ptr+7, all modulo 8.
  - If a winner exists:
    - next state GRANT
    - gnt_bin←winner, gnt_en←1, gnt←one-hot(winner)
    - ptr←winner+1 (mod 8), hold_cnt←0
  - If no winner: next state IDLE, gnt_en=0, gnt=0.
- **GRANT**, evaluated in priority order each edge:
  - done=1 → release, timeout stays 0.
  - req[gnt_bin]=0 (requester dropped) → release, timeout stays 0.
  - hold_cnt==MAX_HOLD-1 → release, timeout←1.
  - Otherwise hold_cnt←hold_cnt+1, stay in GRANT.
- **Release**:
  - next state GAP, gnt_en←0, gnt←0.
  - gnt_bin holds its last value.
- **GAP**:
  - Lasts exactly one cycle with all grants low.
  - timeout is 0 unless set by the release that entered GAP.
  - Arbitrates as in IDLE; if no winner, goes to IDLE.
- The revoked requester may win again after GAP only if no other requester is found first from the advanced ptr.
- gnt_bin, gnt_en and gnt always change together on the same edge; gnt never has more than one bit set.

## Timing
- **Reset values**, applied asynchronously while rst_n=0: state IDLE, ptr=0, hold_cnt=0, gnt_bin=0, gnt_en=0, gnt=8'h00, timeout=0.
- **Grant latency**: req sampled high at edge k in IDLE → grant visible after edge k (one cycle after assertion).
- **Handover**: done sampled at edge n → gnt_en low for cycle n..n+1 (GAP) → next owner granted after edge n+1.
- **Maximum hold**: gnt_en is high for exactly MAX_HOLD consecutive cycles when done=0 and req stays high. With MAX_HOLD=1, every grant lasts one cycle.
- **timeout pulse**: high for exactly the GAP cycle that follows a forced revoke.
- **Wrap-around**: ptr=7 with req=8'h81 → 7 wins; ptr becomes 0.
- **Simultaneous events**:
  - done=1 on the final hold cycle → normal release, timeout=0.
  - A new req arriving during GAP is eligible at that same GAP edge.
- **Reset mid-grant**: outputs clear immediately without waiting for a clock edge. The first edge after rst_n rises arbitrates from ptr=0.

## Test plan
- **Reset mid-grant**: grant active on requester 5, drop rst_n → gnt=8'h00, gnt_en=0, gnt_bin=0, timeout=0 before the next edge. Release rst_n, req=8'h04 → gnt=8'h04, gnt_bin=2 after one edge.
- **Round robin**: req=8'hFF held, done pulsed in each grant cycle → winners 0,1,2,…,7,0, each grant followed by exactly one GAP cycle with gnt=8'h00.
- **Wrap priority**: after requester 6 is granted and released, req=8'h81 → grant 7, then after release and GAP, grant 0.
- **Timeout**: MAX_HOLD=4, req=8'h08 held, done=0 → gnt=8'h08 for 4 cycles, then gnt=0 and timeout=1 for one cycle, then requester 3 is granted again.
- **Requester drop**: requester 5 granted, req[5] falls → gnt_en low after the next edge, timeout=0, ptr=6.
- **Done on the final cycle**: MAX_HOLD=4, done=1 on the 4th grant cycle → release with timeout=0.
